// File: rtl/fdiv_pkg.sv
// Shared definitions for the runtime clock-enable divider:
// state encoding, the power-up divisor and divisor sanitising.
package fdiv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } state_t;

  localparam int unsigned DEFAULT_DIV_50M = 32'd50_000_000;

  // A zero divisor has no meaningful period, so it is treated as 1.
  function automatic logic [63:0] sanitise(input logic [63:0] div);
    return (div == 64'd0) ? 64'd1 : div;
  endfunction

endpackage

// File: rtl/fdiv_core.sv
// Period counter for the divider: counts 1..N while running and drives
// the registered square wave and period strobe.
module fdiv_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_run,
  input  logic             i_run_next,
  input  logic [WIDTH-1:0] i_n,
  output logic             o_wrap,
  output logic             o_fout,
  output logic             o_tick
);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_next;
  logic             r_fout;
  logic             r_tick;
  logic             w_wrap;

  assign w_wrap = (r_count >= i_n);

  // Count is 0 while idle; leaving idle or wrapping restarts at 1.
  always_comb begin
    w_count_next = '0;
    if (i_run_next) begin
      w_count_next = w_wrap ? WIDTH'(1) : r_count + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
      r_fout  <= 1'b0;
      r_tick  <= 1'b0;
    end else begin
      r_count <= w_count_next;
      r_fout  <= (r_count > (i_n >> 1));
      r_tick  <= w_wrap && i_run;
    end
  end

  assign o_wrap = w_wrap;
  assign o_fout = r_fout;
  assign o_tick = r_tick;

endmodule

// File: rtl/fdiv_sched.sv
// Divisor scheduler: accepts new divisors over valid/ready and applies
// them only at a period boundary (or while idle) so fout never glitches.
module fdiv_sched
  import fdiv_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] DEFAULT_DIV = WIDTH'(DEFAULT_DIV_50M),
  parameter int               PCNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [WIDTH-1:0]  div_in,
  input  logic              div_valid,
  output logic              div_ready,
  output logic              fout,
  output logic              tick,
  output logic [WIDTH-1:0]  cur_div,
  output logic [PCNT_W-1:0] periods
);

  state_t            r_state;
  state_t            w_state_next;
  logic [WIDTH-1:0]  r_cur_div;
  logic [WIDTH-1:0]  w_cur_next;
  logic [WIDTH-1:0]  r_pend_div;
  logic [WIDTH-1:0]  w_pend_next;
  logic [WIDTH-1:0]  w_div_san;
  logic [PCNT_W-1:0] r_periods;
  logic              w_xfer;
  logic              w_wrap;
  logic              w_run;
  logic              w_run_next;

  assign div_ready  = rst_n && ((r_state == ST_IDLE) || (r_state == ST_RUN));
  assign w_xfer     = div_valid && div_ready;
  assign w_div_san  = WIDTH'(sanitise(64'(div_in)));
  assign w_run      = (r_state != ST_IDLE);
  assign w_run_next = (w_state_next != ST_IDLE);

  always_comb begin
    w_state_next = r_state;
    w_cur_next   = r_cur_div;
    w_pend_next  = r_pend_div;
    case (r_state)
      ST_IDLE: begin
        if (w_xfer) w_cur_next = w_div_san;
        if (en) w_state_next = ST_RUN;
      end
      ST_RUN: begin
        if (!en) begin
          w_state_next = ST_IDLE;
          if (w_xfer) w_cur_next = w_div_san;
        end else if (w_xfer) begin
          // Even on a wrap edge the new value waits for the next wrap.
          w_pend_next  = w_div_san;
          w_state_next = ST_PEND;
        end
      end
      ST_PEND: begin
        if (!en || w_wrap) begin
          w_cur_next   = r_pend_div;
          w_state_next = en ? ST_RUN : ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cur_div  <= DEFAULT_DIV;
      r_pend_div <= '0;
      r_periods  <= '0;
    end else begin
      r_state    <= w_state_next;
      r_cur_div  <= w_cur_next;
      r_pend_div <= w_pend_next;
      r_periods  <= r_periods + PCNT_W'(w_wrap && w_run);
    end
  end

  fdiv_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_run     (w_run),
    .i_run_next(w_run_next),
    .i_n       (r_cur_div),
    .o_wrap    (w_wrap),
    .o_fout    (fout),
    .o_tick    (tick)
  );

  assign cur_div = r_cur_div;
  assign periods = r_periods;

endmodule

// File: tb/tb_fdiv_sched.sv
// Self-checking bench for fdiv_sched: a power-up table, hand-written
// divisor-change sequences and a randomized run against a period model.
module tb_fdiv_sched;

  localparam int               W   = 32;
  localparam int               PW  = 16;
  localparam logic [W-1:0]     DEF = 32'd4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          div_valid = 1'b0;
  logic [W-1:0]  div_in = '0;
  wire           div_ready;
  wire           fout;
  wire           tick;
  wire  [W-1:0]  cur_div;
  wire  [PW-1:0] periods;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fdiv_sched #(.WIDTH(W), .DEFAULT_DIV(DEF), .PCNT_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .div_in(div_in), .div_valid(div_valid),
    .div_ready(div_ready), .fout(fout), .tick(tick), .cur_div(cur_div), .periods(periods)
  );

  // Model: position inside the current period plus the divisor in force.
  bit          m_active, m_pending, m_fout, m_tick;
  int unsigned m_n, m_pend, m_phase;
  logic [PW-1:0] m_periods;

  typedef struct {
    bit en;
    bit fout;
    bit tick;
    int periods;
  } vec_t;
  vec_t tbl[13];

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_active = 0; m_pending = 0; m_fout = 0; m_tick = 0;
    m_n = DEF; m_pend = 0; m_phase = 0; m_periods = '0;
  endfunction

  function automatic void model_edge();
    bit acc, eop;
    int unsigned v;
    if (!rst_n) begin
      model_reset();
      return;
    end
    acc = div_valid && !m_pending;
    v   = (div_in == 0) ? 1 : div_in;
    eop = m_active && (m_phase == m_n - 1);
    m_tick = eop;
    if (eop) m_periods++;
    m_fout = m_active && (m_phase >= m_n / 2);
    if (!m_active) begin
      if (acc) m_n = v;
      if (en) begin m_active = 1; m_phase = 0; end
    end else if (!en) begin
      m_active = 0;
      if (m_pending) m_n = m_pend;
      if (acc) m_n = v;
      m_pending = 0;
    end else begin
      if (eop) begin
        m_phase = 0;
        if (m_pending) begin m_n = m_pend; m_pending = 0; end
      end else begin
        m_phase++;
      end
      if (acc) begin m_pending = 1; m_pend = v; end
    end
  endfunction

  function automatic void check_model();
    check("mdl_ready", 64'(div_ready), 64'(rst_n && !m_pending));
    check("mdl_fout", 64'(fout), 64'(m_fout));
    check("mdl_tick", 64'(tick), 64'(m_tick));
    check("mdl_cur_div", 64'(cur_div), 64'(m_n));
    check("mdl_periods", 64'(periods), 64'(m_periods));
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_model();
  endtask

  task automatic write_idle(input logic [W-1:0] v);
    en = 1'b0;
    cycle();
    div_valid = 1'b1; div_in = v;
    cycle();
    div_valid = 1'b0;
  endtask

  // Cycles from just after one tick up to and including the next tick.
  task automatic count_to_tick(output int len, output int hi);
    len = 0; hi = 0;
    do begin
      cycle();
      len++;
      if (fout) hi++;
    end while (!tick && len < 300);
    check("tick_timeout", 64'(len >= 300), 64'd0);
  endtask

  task automatic measure_period(output int len, output int hi);
    int g = 0;
    do begin cycle(); g++; end while (!tick && g < 300);
    check("wait_tick_timeout", 64'(g >= 300), 64'd0);
    count_to_tick(len, hi);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, hi, g;
    logic [PW-1:0] exp_p;

    tbl[0]  = '{1, 0, 0, 0}; tbl[1]  = '{1, 0, 0, 0}; tbl[2]  = '{1, 0, 0, 0};
    tbl[3]  = '{1, 1, 0, 0}; tbl[4]  = '{1, 1, 1, 1}; tbl[5]  = '{1, 0, 0, 1};
    tbl[6]  = '{1, 0, 0, 1}; tbl[7]  = '{1, 1, 0, 1}; tbl[8]  = '{1, 1, 1, 2};
    tbl[9]  = '{1, 0, 0, 2}; tbl[10] = '{1, 0, 0, 2}; tbl[11] = '{1, 1, 0, 2};
    tbl[12] = '{1, 1, 1, 3};

    model_reset();
    rst_n = 1'b0;
    repeat (2) cycle();
    check("rst_fout", 64'(fout), 64'd0);
    check("rst_tick", 64'(tick), 64'd0);
    check("rst_cur_div", 64'(cur_div), 64'(DEF));
    check("rst_periods", 64'(periods), 64'd0);
    check("rst_ready", 64'(div_ready), 64'd0);

    // Power-up run at the default divisor of 4.
    rst_n = 1'b1;
    for (int i = 0; i < 13; i++) begin
      en = tbl[i].en;
      cycle();
      check("tbl_fout", 64'(fout), 64'(tbl[i].fout));
      check("tbl_tick", 64'(tick), 64'(tbl[i].tick));
      check("tbl_periods", 64'(periods), 64'(tbl[i].periods));
    end

    // Idle write of 6 applies immediately.
    write_idle(32'd6);
    check("idle_load6", 64'(cur_div), 64'd6);
    en = 1'b1;
    measure_period(len, hi);
    check("n6_len", 64'(len), 64'd6);
    check("n6_hi", 64'(hi), 64'd3);

    // Mid-period write of 10 at count 2 of a 4-cycle period.
    write_idle(32'd4);
    en = 1'b1;
    g = 0;
    do begin cycle(); g++; end while (!(m_active && m_phase == 1) && g < 50);
    check("mid_align_timeout", 64'(g >= 50), 64'd0);
    check("mid_ready_before", 64'(div_ready), 64'd1);
    div_valid = 1'b1; div_in = 32'd10;
    cycle();
    div_valid = 1'b0;
    check("mid_ready_pend", 64'(div_ready), 64'd0);
    g = 0;
    while (!tick && g < 50) begin
      check("mid_cur_old", 64'(cur_div), 64'd4);
      cycle();
      g++;
    end
    check("mid_cur_at_wrap", 64'(cur_div), 64'd10);
    check("mid_ready_after", 64'(div_ready), 64'd1);
    count_to_tick(len, hi);
    check("n10_len", 64'(len), 64'd10);
    check("n10_hi", 64'(hi), 64'd5);

    // Write landing exactly on a wrap edge: one more 4-period, then 8s.
    write_idle(32'd4);
    en = 1'b1;
    g = 0;
    do begin cycle(); g++; end while (!(m_active && !m_pending && m_phase == 3) && g < 50);
    check("wrap_align_timeout", 64'(g >= 50), 64'd0);
    div_valid = 1'b1; div_in = 32'd8;
    cycle();
    div_valid = 1'b0;
    check("wrap_tick", 64'(tick), 64'd1);
    check("wrap_cur_old", 64'(cur_div), 64'd4);
    count_to_tick(len, hi);
    check("wrap_len4", 64'(len), 64'd4);
    for (int k = 0; k < 3; k++) begin
      count_to_tick(len, hi);
      check("wrap_len8", 64'(len), 64'd8);
      check("wrap_hi8", 64'(hi), 64'd4);
    end

    // Divisor 0 is stored as 1: fout steady high, tick every cycle.
    write_idle(32'd0);
    check("zero_cur", 64'(cur_div), 64'd1);
    en = 1'b1;
    repeat (2) cycle();
    exp_p = m_periods;
    for (int k = 0; k < 8; k++) begin
      cycle();
      exp_p = exp_p + 1'b1;
      check("n1_fout", 64'(fout), 64'd1);
      check("n1_tick", 64'(tick), 64'd1);
      check("n1_periods", 64'(periods), 64'(exp_p));
    end

    // Reset while a divisor is pending discards it.
    write_idle(32'd5);
    en = 1'b1;
    repeat (7) cycle();
    div_valid = 1'b1; div_in = 32'd9;
    cycle();
    div_valid = 1'b0;
    check("pend_ready", 64'(div_ready), 64'd0);
    rst_n = 1'b0;
    cycle();
    check("mrst_cur", 64'(cur_div), 64'(DEF));
    check("mrst_fout", 64'(fout), 64'd0);
    check("mrst_tick", 64'(tick), 64'd0);
    check("mrst_periods", 64'(periods), 64'd0);
    check("mrst_ready", 64'(div_ready), 64'd0);
    rst_n = 1'b1;
    measure_period(len, hi);
    check("mrst_len", 64'(len), 64'(DEF));

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      rst_n     = ($urandom_range(0, 199) != 0);
      en        = ($urandom_range(0, 15) != 0);
      div_valid = ($urandom_range(0, 4) == 0);
      div_in    = 32'($urandom_range(0, 12));
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fdiv_sched.md
Name: fdiv_sched

Overview:
- Runtime controller for the board's clock-enable divider.
- Holds the active divisor, accepts new divisors over a valid/ready handshake, and applies each one only at a period boundary, so outputs never glitch.
- Produces a divided square wave (fout) and a one-cycle period strobe (tick) that downstream lab logic uses as a clock enable.
- Sits between the switch/UART configuration logic and all rate-dependent consumers (LED blinkers, counters, display scan).

Parameters:
- WIDTH, 32, width of the divisor, counter and div_in.
- DEFAULT_DIV, 50000000, divisor loaded at reset (1 Hz at 50 MHz).
- PCNT_W, 16, width of the completed-period counter.

Ports:
- clk  in  1  system clock (50 MHz).
- rst_n  in  1  synchronous active-low reset, sampled on the clk rising edge.
- en  in  1  run enable; 0 forces IDLE.
- div_in  in  WIDTH  requested divisor.
- div_valid  in  1  div_in is valid this cycle.
- div_ready  out  1  block can accept div_in this cycle.
- fout  out  1  divided square wave, registered.
- tick  out  1  one-cycle strobe per completed period, registered.
- cur_div  out  WIDTH  divisor currently in effect.
- periods  out  PCNT_W  completed-period count; wraps modulo 2^PCNT_W.

Behaviour:
- One clock domain. All state updates on the rising edge of clk. Reset is synchronous, active-low.
- Reset values:
  - state = IDLE, count = 0, cur_div = DEFAULT_DIV, pend_div = 0.
  - fout = 0, tick = 0, periods = 0.
  - div_ready = 0 while rst_n = 0.
- Divisor sanitising: a divisor of 0 is stored as 1. No other clamping.
- Handshake:
  - Transfer occurs when div_valid && div_ready on the same edge.
  - div_ready is high in IDLE and RUN, low in PEND and during reset.
  - div_valid with div_ready low is ignored; the requester must hold the value.
- States:
  - IDLE: count held at 0; fout = 0, tick = 0.
    - A transfer loads cur_div directly.
    - en = 1 -> RUN; count = 1 on the next edge.
  - RUN: count sequences 1, 2, ..., N, 1, ... with N = cur_div. The wrap condition is count >= N.
    - A transfer loads pend_div -> PEND.
    - en = 0 -> IDLE.
  - PEND: counting continues with the old N.
    - On the first wrap edge after acceptance: cur_div <= pend_div, count <= 1, -> RUN.
    - en = 0 -> IDLE, with cur_div <= pend_div applied on that same edge.
- Same-cycle events:
  - A transfer accepted on a wrap edge in RUN does not affect that wrap. It applies at the following wrap.
  - en = 0 together with an accepted transfer in RUN: go to IDLE and load cur_div with the new value.
- Outputs, one cycle latency from count:
  - fout(t+1) = (count(t) > (N >> 1)).
  - tick(t+1) = (count(t) >= N) && state != IDLE.
  - periods increments on every cycle tick is asserted.
  - Result: period is exactly N cycles, with fout high for N - floor(N/2) cycles.
- N = 1: in RUN, fout is constant 1 and tick is asserted every cycle. clk is never routed onto fout.
- Reset mid-operation: behaves exactly as power-up. Any pending divisor is discarded.
- Width rules:
  - count comparisons are unsigned WIDTH-bit.
  - count never exceeds N because cur_div changes only at a wrap or in IDLE.

Decomposition:
- Package fdiv_pkg holds:
  - State encoding: IDLE = 2'd0, RUN = 2'd1, PEND = 2'd2.
  - DEFAULT_DIV_50M.
  - A sanitise function mapping 0 -> 1.
- Sub-module fdiv_core: count register, wrap/compare logic, and fout/tick output registers. It takes N and run as inputs.
- fdiv_sched holds the FSM, the handshake, cur_div/pend_div and periods.

Test Plan:
- Reset with DEFAULT_DIV overridden to 4, then en = 1 -> count 1, 2, 3, 4, 1. fout (1-cycle lag) reads 0, 0, 1, 1 and repeats. tick is high one cycle in 4. periods = 3 after 12 cycles.
- In IDLE, write div_in = 6 -> cur_div = 6 on the next edge. With en = 1: period 6, fout high 3 cycles, low 3 cycles.
- RUN at N = 4, write 10 at count = 2 -> div_ready is 0 until the wrap. The current period completes at 4. The next period is 10 cycles with fout high 5. cur_div changes exactly at the wrap edge.
- Write timed on the wrap edge at N = 4 -> one more 4-cycle period, then 8-cycle periods. Assert that no period has a length other than 4 or 8.
- Write div_in = 0, then en = 1 -> cur_div = 1, fout held at 1, tick every cycle, periods increments each cycle.
- rst_n = 0 for one cycle mid-PEND at N = 5 -> next cycle: IDLE, cur_div = DEFAULT_DIV, pending value lost, fout = tick = 0, periods = 0.
